// File: rtl/prog_mem_reader.sv
// Program-memory read-back engine: walks the program memory from address 0 and
// streams every word MSB-first as bytes on a valid/ready interface.
module prog_mem_reader #(
   parameter int NB_ADDR   = 5,
   parameter int NB_DATA   = 32,
   parameter int NB_BYTE   = 8,
   parameter int MEM_DEPTH = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   output logic               o_mem_rd_enb,
   output logic [NB_ADDR-1:0] o_mem_rd_addr,
   input  logic [NB_DATA-1:0] i_mem_rd_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic [NB_ADDR:0]   o_word_count
);

   // state     | meaning
   // ST_IDLE   | waiting for i_start
   // ST_READ   | read strobe for current address
   // ST_WAIT   | synchronous RAM latency, word captured at end of cycle
   // ST_SEND   | bytes offered to TX, MSB first
   // ST_NEXT   | stop on terminator / last address, else advance
   // ST_DONE   | one-cycle completion pulse

   localparam int NBYTES = NB_DATA / NB_BYTE;
   localparam int NB_SEL = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [NB_SEL-1:0]  FIRST_SEL = NB_SEL'(NBYTES - 1);
   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_SEND,
      ST_NEXT,
      ST_DONE
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [NB_ADDR-1:0] addr;
   logic [NB_SEL-1:0]  byte_sel;
   logic [NB_DATA-1:0] word;
   logic [NB_ADDR:0]   word_count;
   logic               tx_fire;
   logic               last_byte;
   logic               stop;

   // byte_sel counts down to 0, so it is directly the byte lane to send
   assign tx_fire       = (state == ST_SEND) && i_tx_ready;
   assign last_byte     = (byte_sel == '0);
   assign stop          = (word == '0) || (addr == LAST_ADDR);
   assign o_tx_data     = NB_BYTE'(word >> (byte_sel * NB_BYTE));
   assign o_mem_rd_addr = addr;
   assign o_busy        = (state != ST_IDLE);
   assign o_word_count  = word_count;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      o_mem_rd_enb = 1'b0;
      o_tx_valid   = 1'b0;
      o_done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) state_next = ST_READ;
         end
         ST_READ: begin
            o_mem_rd_enb = 1'b1;
            state_next   = ST_WAIT;
         end
         ST_WAIT: begin
            state_next = ST_SEND;
         end
         ST_SEND: begin
            o_tx_valid = 1'b1;
            if (i_tx_ready && last_byte) state_next = ST_NEXT;
         end
         ST_NEXT: begin
            state_next = stop ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            o_done     = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         addr       <= '0;
         byte_sel   <= '0;
         word       <= '0;
         word_count <= '0;
      end else begin
         if ((state == ST_IDLE) && i_start) begin
            addr       <= '0;
            byte_sel   <= FIRST_SEL;
            word_count <= '0;
         end
         if (state == ST_WAIT) begin
            word     <= i_mem_rd_data;
            byte_sel <= FIRST_SEL;
         end
         if (tx_fire) begin
            if (last_byte) begin
               word_count <= word_count + 1'b1;
            end else begin
               byte_sel <= byte_sel - 1'b1;
            end
         end
         if ((state == ST_NEXT) && !stop) begin
            addr <= addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prog_mem_reader.sv
// Scoreboard bench for prog_mem_reader: a memory model plus a high-level dump
// model feed expected bytes and word counts; a negedge monitor checks them.
module tb_prog_mem_reader;

   localparam int NB_ADDR   = 5;
   localparam int NB_DATA   = 32;
   localparam int NB_BYTE   = 8;
   localparam int MEM_DEPTH = 32;

   logic               tb_clock = 1'b0;
   logic               tb_reset = 1'b0;
   logic               start    = 1'b0;
   logic               tx_ready = 1'b0;
   logic               mem_rd_enb;
   logic [NB_ADDR-1:0] mem_rd_addr;
   logic [NB_DATA-1:0] mem_rd_data = '0;
   logic [NB_BYTE-1:0] tx_data;
   logic               tx_valid;
   logic               busy;
   logic               done;
   logic [NB_ADDR:0]   word_count;

   logic [NB_DATA-1:0] mem [MEM_DEPTH];
   logic [NB_BYTE-1:0] exp_bytes [$];
   int                 exp_cnt [$];
   int                 checks = 0;
   int                 errors = 0;
   int                 ready_mode = 0;

   prog_mem_reader #(
      .NB_ADDR  (NB_ADDR),
      .NB_DATA  (NB_DATA),
      .NB_BYTE  (NB_BYTE),
      .MEM_DEPTH(MEM_DEPTH)
   ) dut (
      .i_clock      (tb_clock),
      .i_reset      (tb_reset),
      .i_start      (start),
      .o_mem_rd_enb (mem_rd_enb),
      .o_mem_rd_addr(mem_rd_addr),
      .i_mem_rd_data(mem_rd_data),
      .o_tx_data    (tx_data),
      .o_tx_valid   (tx_valid),
      .i_tx_ready   (tx_ready),
      .o_busy       (busy),
      .o_done       (done),
      .o_word_count (word_count)
   );

   always #5 tb_clock = ~tb_clock;

   always @(posedge tb_clock) begin
      if (mem_rd_enb) mem_rd_data <= mem[mem_rd_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: words from address 0 upward, each sent MSB first, stopping
   // after the zero word (sent too) or after the last address.
   task automatic push_model();
      int cnt;
      logic [NB_DATA-1:0] w;
      cnt = 0;
      for (int a = 0; a < MEM_DEPTH; a++) begin
         w = mem[a];
         for (int b = NB_DATA / NB_BYTE - 1; b >= 0; b--) exp_bytes.push_back(w[b*NB_BYTE +: NB_BYTE]);
         cnt++;
         if (w == 0) break;
      end
      exp_cnt.push_back(cnt);
   endtask

   // Ready pattern: 0 always, 1 one-of-three, 2 random, 3 never.
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge tb_clock);
         #1;
         case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin
               tx_ready = (phase == 0);
               phase    = (phase + 1) % 3;
            end
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
         endcase
      end
   end

   initial begin
      logic               stalled;
      logic [NB_BYTE-1:0] stall_data;
      logic [NB_BYTE-1:0] eb;
      stalled    = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge tb_clock);
         if (!tb_reset) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", tx_valid, 1);
               check("stall_data", tx_data, stall_data);
            end
            if (tx_valid && tx_ready) begin
               check("byte_expected", exp_bytes.size() != 0, 1);
               if (exp_bytes.size() != 0) begin
                  eb = exp_bytes.pop_front();
                  check("tx_byte", tx_data, eb);
               end
            end
            stalled    = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (done) begin
               check("done_expected", exp_cnt.size() != 0, 1);
               if (exp_cnt.size() != 0) check("word_count", word_count, exp_cnt.pop_front());
               check("bytes_all_sent", exp_bytes.size(), 0);
            end
         end
      end
   end

   task automatic wait_done(inout int n);
      while (!done && n < 3000) begin
         @(posedge tb_clock);
         #1;
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic run_dump(input bit timing, input int exp_cycles);
      int n;
      @(posedge tb_clock);
      #1 start = 1'b1;
      push_model();
      @(posedge tb_clock);
      #1 start = 1'b0;
      n = 0;
      if (timing) begin
         check("rd_enb_e0", mem_rd_enb, 1);
         check("rd_addr_e0", mem_rd_addr, 0);
         check("busy_e0", busy, 1);
         @(posedge tb_clock);
         #1 n++;
         check("rd_enb_e1", mem_rd_enb, 0);
         check("valid_e1", tx_valid, 0);
         @(posedge tb_clock);
         #1 n++;
         check("valid_e2", tx_valid, 1);
      end
      wait_done(n);
      if (exp_cycles >= 0) check("start_to_done", n, exp_cycles);
   endtask

   task automatic load_prog();
      for (int a = 0; a < MEM_DEPTH; a++) mem[a] = 32'hFFFF_0000 | a;
      mem[0] = 32'h8C01_0004;
      mem[1] = 32'h0022_1820;
      mem[2] = 32'h0000_0000;
   endtask

   initial begin
      int n;
      int pos;
      load_prog();
      repeat (3) @(posedge tb_clock);
      #1;
      check("rst_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", word_count, 0);
      check("rst_rd_enb", mem_rd_enb, 0);
      check("rst_data", tx_data, 0);
      @(negedge tb_clock) tb_reset = 1'b1;

      ready_mode = 0;
      run_dump(1, 21);

      ready_mode = 1;
      run_dump(0, -1);

      ready_mode = 0;
      for (int a = 0; a < MEM_DEPTH; a++) mem[a] = a + 1;
      run_dump(0, MEM_DEPTH * 7);

      // restart attempts while busy and on the DONE cycle
      load_prog();
      @(posedge tb_clock);
      #1 start = 1'b1;
      push_model();
      @(posedge tb_clock);
      #1 start = 1'b0;
      n = 0;
      while (!(tx_valid && mem_rd_addr == 1) && n < 100) begin
         @(posedge tb_clock);
         #1 n++;
      end
      check("word1_send_reached", tx_valid && (mem_rd_addr == 1), 1);
      start = 1'b1;
      @(posedge tb_clock);
      #1 start = 1'b0;
      n = 0;
      wait_done(n);
      start = 1'b1;
      @(posedge tb_clock);
      #1 start = 1'b0;
      check("start_on_done_ignored", busy, 0);
      repeat (3) @(posedge tb_clock);
      #1 check("idle_after_done", busy, 0);
      run_dump(0, 21);

      // reset while a byte is stalled
      ready_mode = 2;
      @(posedge tb_clock);
      #1 start = 1'b1;
      push_model();
      @(posedge tb_clock);
      #1 start = 1'b0;
      n = 0;
      while (!(tx_valid && word_count >= 1) && n < 500) begin
         @(posedge tb_clock);
         #1 n++;
      end
      check("mid_dump_reached", tx_valid && (word_count >= 1), 1);
      ready_mode = 3;
      @(posedge tb_clock);
      #3 tb_reset = 1'b0;
      #1;
      check("abort_valid", tx_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_count", word_count, 0);
      check("abort_done", done, 0);
      exp_bytes.delete();
      exp_cnt.delete();
      repeat (3) @(posedge tb_clock);
      @(negedge tb_clock) tb_reset = 1'b1;
      ready_mode = 0;
      run_dump(1, 21);

      for (int a = 0; a < MEM_DEPTH; a++) mem[a] = $urandom | 32'h1;
      mem[0] = 32'h0;
      run_dump(0, 7);

      ready_mode = 2;
      for (int t = 0; t < 4; t++) begin
         for (int a = 0; a < MEM_DEPTH; a++) mem[a] = $urandom | 32'h100;
         pos = $urandom_range(0, 40);
         if (pos < MEM_DEPTH) mem[pos] = 32'h0;
         run_dump(0, -1);
      end

      repeat (4) @(posedge tb_clock);
      check("leftover_bytes", exp_bytes.size(), 0);
      check("leftover_dones", exp_cnt.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected below 600000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
